// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the shared UART
// transmitter and the round-robin arbiter that sits between them.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int GID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           req_last;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         tx_start;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         tx_busy;
   logic                         grant_active;
   logic [GID_W-1:0]             grant_id;
   logic                         timeout_pulse;

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_start, tx_data, grant_active, grant_id, timeout_pulse
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_start, tx_data, grant_active, grant_id, timeout_pulse
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte streams,
// with packet-long grants and a stall timeout that frees a silent owner.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8,
   parameter int TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int GID_W = $clog2(NUM_REQ);
   localparam int SW    = GID_W + 1;
   localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : {TO_W{1'b0}};
   localparam logic [GID_W-1:0] GID_MAX = GID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t               state_r;
   logic [GID_W-1:0]     rr_ptr_r;
   logic [GID_W-1:0]     grant_id_r;
   logic                 grant_active_r;
   logic                 tx_start_r;
   logic                 timeout_pulse_r;
   logic                 last_r;
   logic [DATA_BITS-1:0] tx_data_r;
   logic [TO_W-1:0]      to_cnt_r;

   logic [DATA_BITS-1:0] req_bytes_s [NUM_REQ];
   logic [SW-1:0]        pick_s;
   logic                 send_open_s;
   logic                 xfer_s;
   logic [GID_W-1:0]     next_ptr_s;
   logic [NUM_REQ-1:0]   ready_s;

   // Returns {found, index}; scanning downward lets the closest index to ptr win.
   function automatic logic [SW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [GID_W-1:0]   ptr);
      logic [SW-1:0] res;
      logic [SW-1:0] idx;
      res = {SW{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr} + SW'(k);
         if (idx >= SW'(NUM_REQ)) begin
            idx = idx - SW'(NUM_REQ);
         end
         if (valid[idx[GID_W-1:0]]) begin
            res = {1'b1, idx[GID_W-1:0]};
         end
      end
      return res;
   endfunction

   // Unpack the flat requester byte bus
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_bytes_s[i] = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
   end

   assign pick_s      = rr_pick(bus.req_valid, rr_ptr_r);
   assign send_open_s = (state_r == SEND) && !bus.tx_busy;
   assign xfer_s      = send_open_s && bus.req_valid[grant_id_r];
   assign next_ptr_s  = (grant_id_r == GID_MAX) ? {GID_W{1'b0}} : grant_id_r + GID_W'(1);

   // Only the owner is ever readied, and only while the transmitter is idle
   always_comb begin
      ready_s = {NUM_REQ{1'b0}};
      if (send_open_s) begin
         ready_s[grant_id_r] = 1'b1;
      end else begin
         ready_s = {NUM_REQ{1'b0}};
      end
   end

   // Arbitration / launch sequencer with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         rr_ptr_r        <= {GID_W{1'b0}};
         grant_id_r      <= {GID_W{1'b0}};
         grant_active_r  <= 1'b0;
         tx_start_r      <= 1'b0;
         timeout_pulse_r <= 1'b0;
         last_r          <= 1'b0;
         tx_data_r       <= {DATA_BITS{1'b0}};
         to_cnt_r        <= {TO_W{1'b0}};
      end else begin
         tx_start_r      <= 1'b0;
         timeout_pulse_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pick_s[SW-1]) begin
                  grant_id_r     <= pick_s[GID_W-1:0];
                  grant_active_r <= 1'b1;
                  to_cnt_r       <= {TO_W{1'b0}};
                  state_r        <= SEND;
               end
            end
            SEND: begin
               // A transfer on the timeout edge wins over the release
               if (xfer_s) begin
                  tx_data_r  <= req_bytes_s[grant_id_r];
                  last_r     <= bus.req_last[grant_id_r];
                  tx_start_r <= 1'b1;
                  to_cnt_r   <= {TO_W{1'b0}};
                  state_r    <= WAIT_BUSY;
               end else if ((TIMEOUT != 0) && (to_cnt_r == TO_LAST)) begin
                  timeout_pulse_r <= 1'b1;
                  grant_active_r  <= 1'b0;
                  rr_ptr_r        <= next_ptr_s;
                  to_cnt_r        <= {TO_W{1'b0}};
                  state_r         <= IDLE;
               end else if (to_cnt_r != {TO_W{1'b1}}) begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state_r <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  if (last_r) begin
                     grant_active_r <= 1'b0;
                     rr_ptr_r       <= next_ptr_s;
                     state_r        <= IDLE;
                  end else begin
                     state_r <= SEND;
                  end
               end
            end
            default: begin
               grant_active_r <= 1'b0;
               state_r        <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = ready_s;
   assign bus.tx_start      = tx_start_r;
   assign bus.tx_data       = tx_data_r;
   assign bus.grant_active  = grant_active_r;
   assign bus.grant_id      = grant_id_r;
   assign bus.timeout_pulse = timeout_pulse_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte lists feed the DUT,
// the bench plays the transmitter's busy line and compares against hand values.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mem [4][8];
   logic       lst [4][8];
   int         rd  [4];
   int         cnt [4];
   logic       watch2 = 1'b0;
   logic       viol2  = 1'b0;
   logic       multi  = 1'b0;
   logic [7:0] b;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

   uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .TIMEOUT(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Watch for a ready leaking to requester 2 during the lock test, or two readies at once
   always @(negedge clk) begin
      if (watch2 && bus.req_ready[2]) viol2 <= 1'b1;
      if ($countones(bus.req_ready) > 1) multi <= 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) begin
         if (rd[i] < cnt[i]) begin
            bus.req_valid[i]       = 1'b1;
            bus.req_data[i*8 +: 8] = mem[i][rd[i]];
            bus.req_last[i]        = lst[i][rd[i]];
         end else begin
            bus.req_valid[i]       = 1'b0;
            bus.req_data[i*8 +: 8] = 8'h00;
            bus.req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic l);
      if (cnt[i] < 8) begin
         mem[i][cnt[i]] = d;
         lst[i][cnt[i]] = l;
         cnt[i]++;
      end
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      bus.tx_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd[i]  = 0;
         cnt[i] = 0;
      end
      refresh();
      cyc();
      cyc();
      reset_n = 1'b1;
   endtask

   // Wait for a launch, retire the accepted byte, then play a 3-cycle busy frame
   task automatic serve(output logic [7:0] got);
      int n;
      int id;
      n = 0;
      while (bus.tx_start !== 1'b1 && n < 60) begin
         cyc();
         n++;
      end
      chk("start_seen", bus.tx_start, 1'b1);
      got = bus.tx_data;
      id  = int'(bus.grant_id);
      rd[id]++;
      refresh();
      cyc();
      bus.tx_busy = 1'b1;
      repeat (3) cyc();
      bus.tx_busy = 1'b0;
   endtask

   initial begin
      do_reset();
      reset_n = 1'b0;
      cyc();
      chk("rst_grant_active", bus.grant_active, 1'b0);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_grant_id", bus.grant_id, 2'd0);
      chk("rst_timeout", bus.timeout_pulse, 1'b0);
      chk("rst_ready", bus.req_ready, 4'b0000);
      reset_n = 1'b1;

      // Single byte from requester 1
      load(1, 8'hA5, 1'b1);
      refresh();
      cyc();
      chk("single_ready", bus.req_ready, 4'b0010);
      chk("single_active", bus.grant_active, 1'b1);
      chk("single_gid", bus.grant_id, 2'd1);
      chk("single_nostart", bus.tx_start, 1'b0);
      cyc();
      chk("single_ready_off", bus.req_ready, 4'b0000);
      chk("single_start", bus.tx_start, 1'b1);
      chk("single_data", bus.tx_data, 8'hA5);
      rd[1]++;
      refresh();
      cyc();
      chk("single_start_off", bus.tx_start, 1'b0);
      bus.tx_busy = 1'b1;
      repeat (3) cyc();
      chk("single_held", bus.grant_active, 1'b1);
      bus.tx_busy = 1'b0;
      cyc();
      chk("single_release", bus.grant_active, 1'b0);
      chk("single_gid_hold", bus.grant_id, 2'd1);
      load(0, 8'h20, 1'b1);
      load(2, 8'h22, 1'b1);
      load(3, 8'h23, 1'b1);
      refresh();
      cyc();
      chk("rrptr_gid", bus.grant_id, 2'd2);
      chk("rrptr_ready", bus.req_ready, 4'b0100);
      serve(b); chk("wrap_0", b, 8'h22);
      serve(b); chk("wrap_1", b, 8'h23);
      serve(b); chk("wrap_2", b, 8'h20);

      // Fairness over two rounds
      do_reset();
      for (int i = 0; i < 4; i++) load(i, 8'h10 + 8'(i), 1'b1);
      for (int i = 0; i < 4; i++) load(i, 8'h14 + 8'(i), 1'b1);
      refresh();
      for (int k = 0; k < 8; k++) begin
         serve(b);
         chk("fair_order", b, 8'h10 + 8'(k));
      end

      // Packet lock against a continuously valid requester 2
      do_reset();
      load(0, 8'h01, 1'b0);
      load(0, 8'h02, 1'b0);
      load(0, 8'h03, 1'b1);
      load(2, 8'hEE, 1'b1);
      refresh();
      watch2 = 1'b1;
      serve(b); chk("lock_0", b, 8'h01);
      serve(b); chk("lock_1", b, 8'h02);
      serve(b); chk("lock_2", b, 8'h03);
      watch2 = 1'b0;
      serve(b); chk("lock_3", b, 8'hEE);
      chk("lock_no_ready2", viol2, 1'b0);

      // Stall timeout: requester 1 goes silent mid-packet
      do_reset();
      load(1, 8'h55, 1'b0);
      load(3, 8'h77, 1'b1);
      refresh();
      serve(b); chk("to_first", b, 8'h55);
      cyc();
      chk("to_send_active", bus.grant_active, 1'b1);
      chk("to_pulse_early", bus.timeout_pulse, 1'b0);
      repeat (15) cyc();
      chk("to_pulse_15", bus.timeout_pulse, 1'b0);
      cyc();
      chk("to_pulse_16", bus.timeout_pulse, 1'b1);
      chk("to_release", bus.grant_active, 1'b0);
      cyc();
      chk("to_pulse_off", bus.timeout_pulse, 1'b0);
      chk("to_regrant", bus.grant_active, 1'b1);
      chk("to_next_gid", bus.grant_id, 2'd3);
      serve(b); chk("to_next_byte", b, 8'h77);

      // Busy gating on entry to SEND
      do_reset();
      bus.tx_busy = 1'b1;
      load(0, 8'h5A, 1'b1);
      refresh();
      cyc();
      chk("gate_active", bus.grant_active, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("gate_ready", bus.req_ready, 4'b0000);
         chk("gate_start", bus.tx_start, 1'b0);
         cyc();
      end
      bus.tx_busy = 1'b0;
      #1;
      chk("gate_ready_open", bus.req_ready, 4'b0001);
      cyc();
      chk("gate_start_go", bus.tx_start, 1'b1);
      chk("gate_data", bus.tx_data, 8'h5A);
      rd[0]++;
      refresh();
      cyc();
      bus.tx_busy = 1'b1;
      repeat (2) cyc();
      bus.tx_busy = 1'b0;
      cyc();
      chk("gate_release", bus.grant_active, 1'b0);

      // Asynchronous reset in the middle of WAIT_DONE
      do_reset();
      load(0, 8'h61, 1'b0);
      load(0, 8'h62, 1'b1);
      load(1, 8'h71, 1'b1);
      refresh();
      for (int n = 0; n < 20 && bus.tx_start !== 1'b1; n++) cyc();
      chk("ar_start", bus.tx_start, 1'b1);
      chk("ar_data", bus.tx_data, 8'h61);
      rd[0]++;
      refresh();
      cyc();
      bus.tx_busy = 1'b1;
      repeat (2) cyc();
      chk("ar_pre_active", bus.grant_active, 1'b1);
      #4;
      reset_n = 1'b0;
      #1;
      chk("ar_active", bus.grant_active, 1'b0);
      chk("ar_tx_start", bus.tx_start, 1'b0);
      chk("ar_ready", bus.req_ready, 4'b0000);
      chk("ar_tx_data", bus.tx_data, 8'h00);
      chk("ar_gid", bus.grant_id, 2'd0);
      bus.tx_busy = 1'b0;
      cyc();
      reset_n = 1'b1;
      cyc();
      chk("ar_first_active", bus.grant_active, 1'b1);
      chk("ar_first_gid", bus.grant_id, 2'd0);
      serve(b); chk("ar_first_byte", b, 8'h62);

      chk("ready_onehot", multi, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
